mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: READ_LAT, default 1, meaning cycles mem_read_en is held before mem_data_out is sampled; legal range 1..3.
REQ-002 clock  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  request pending from requester N (N = 0, 1).
REQ-005 reqN_write  input  1  1 = write, 0 = read, for requester N.
REQ-006 reqN_address  input  3  target memory line for requester N.
REQ-007 reqN_wdata  input  8  write data from requester N.
REQ-008 reqN_ready  output  1  single-cycle accept pulse to requester N.
REQ-009 reqN_rvalid  output  1  single-cycle read-data-valid pulse to requester N.
REQ-010 rdata  output  8  read data register, shared by both requesters.
REQ-011 clear_req  input  1  level request to clear all memory lines.
REQ-012 clear_done  output  1  single-cycle pulse when the clear executes.
REQ-013 mem_address  output  3  address to the 8x8 memory.
REQ-014 mem_data_in  output  8  write data to memory.
REQ-015 mem_chip_select, mem_read_en, mem_write_en, mem_reset  output  1 each  memory controls.
REQ-016 mem_data_out  input  8  read data from memory.

Function
REQ-017 The FSM SHALL have the states IDLE, WRITE, READ, RESP and CLEAR.
REQ-018 In IDLE with clear_req=1, the FSM SHALL go to CLEAR; clear takes priority over both requesters.
REQ-019 In IDLE with clear_req=0, reqN_ready SHALL be asserted combinationally for the selected requester only.
REQ-020 Selection SHALL follow these rules: a single valid requester wins; if both are valid, the requester not in last_grant wins.
REQ-021 A request SHALL be accepted on the edge where reqN_valid && reqN_ready.
REQ-022 On acceptance the block SHALL latch address, wdata, write and the grant ID, update last_grant, and go to WRITE or READ.
REQ-023 Requesters SHALL hold valid and their fields stable until ready; behaviour when valid is withdrawn early is undefined.
REQ-024 WRITE SHALL last exactly 1 cycle with mem_chip_select=1, mem_write_en=1 and the latched address/data, then return to IDLE.
REQ-025 READ SHALL last READ_LAT cycles with mem_chip_select=1 and mem_read_en=1; mem_data_out SHALL be captured into rdata on the last READ edge.
REQ-026 RESP SHALL last 1 cycle with rvalid asserted for the granted requester only, then return to IDLE.
REQ-027 Latency: with acceptance at edge T, the write strobe SHALL be in cycle T+1 and rvalid SHALL be in cycle T+READ_LAT+1.
REQ-028 Throughput: a write SHALL occupy 2 cycles and a read READ_LAT+2 cycles, both including the IDLE grant cycle.
REQ-029 CLEAR SHALL last 1 cycle with mem_reset=1 and clear_done=1, then return to IDLE.
REQ-030 mem_read_en and mem_write_en SHALL never be high together.
REQ-031 mem_chip_select SHALL be high only in WRITE and READ.
REQ-032 Outside WRITE and READ, mem_address and mem_data_in SHALL hold their latched values and all strobes SHALL be 0.
REQ-033 rdata SHALL hold its value until the next read capture.
REQ-034 Fairness: a continuously valid requester SHALL be granted within one transaction of the other requester.

Reset
REQ-035 While reset=1, the block SHALL drive mem_reset=1, so memory is cleared alongside the controller.
REQ-036 On reset the block SHALL set state=IDLE, last_grant=1 (req0 wins the first tie), latched address/data=0 and rdata=0x00.
REQ-037 On reset the block SHALL drive all ready, rvalid, clear_done, chip_select, read_en and write_en outputs to 0.
REQ-038 A reset asserted mid-transaction SHALL abandon the transaction: no rvalid is issued, no write strobe follows, and the block is in IDLE on the cycle after reset deasserts.

Verification
REQ-039 Write then read: reset; req0 writes addr 5 = 0xA5; req1 reads addr 5 -> req1_rvalid READ_LAT+1 cycles after accept, rdata=0xA5, req0_rvalid stays 0.
REQ-040 Tie then alternation: both valid together after reset, continuously -> grants go req0, req1, req0, req1; ready is never high on both.
REQ-041 Clear priority: clear_req and req0 read of addr 2 (holding 0x3C) raised together -> CLEAR first (mem_reset and clear_done high 1 cycle), then req0 is served with rdata=0x00.
REQ-042 Reset mid-read: READ_LAT=3, reset asserted in the second READ cycle -> no rvalid, all strobes 0 on the next cycle, IDLE afterwards.
REQ-043 Full sweep: write addr k = k*0x11 for k=0..7 from alternating requesters, then read all back -> every rdata matches; a checker confirms REQ-030/031 on every cycle.
REQ-044 Parameter sweep: repeat REQ-039 for READ_LAT=1, 2, 3 -> measured latency equals READ_LAT+1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of an 8x8 single-port memory.
// Alternating-priority grant, single-cycle writes, READ_LAT-cycle reads, one-cycle clear.
//
// state | meaning
// IDLE  | pick a requester (or clear) and latch its request
// WRITE | one-cycle write strobe with latched address/data
// READ  | READ_LAT cycles of read strobe; capture on the last edge
// RESP  | one-cycle rvalid to the granted requester
// CLEAR | one-cycle memory reset, clear_done pulse
module mem_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic [2:0] req0_address,
    input  logic [7:0] req0_wdata,
    output logic       req0_ready,
    output logic       req0_rvalid,
    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic [2:0] req1_address,
    input  logic [7:0] req1_wdata,
    output logic       req1_ready,
    output logic       req1_rvalid,
    output logic [7:0] rdata,
    input  logic       clear_req,
    output logic       clear_done,
    output logic [2:0] mem_address,
    output logic [7:0] mem_data_in,
    output logic       mem_chip_select,
    output logic       mem_read_en,
    output logic       mem_write_en,
    output logic       mem_reset,
    input  logic [7:0] mem_data_out
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, CLEAR} state_t;

    localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

    state_t     state, state_nxt;
    logic [1:0] lat_cnt;
    logic [2:0] addr_q;
    logic [7:0] wdata_q;
    logic       grant_q;
    logic       last_grant;
    logic       sel0, sel1, accept, sel_write;

    // On a tie the requester that was not granted last time wins.
    assign sel1      = req1_valid && (!req0_valid || !last_grant);
    assign sel0      = req0_valid && !sel1;
    assign accept    = (state == IDLE) && !clear_req && (sel0 || sel1);
    assign sel_write = sel1 ? req1_write : req0_write;

    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;

    always_comb begin
        state_nxt       = state;
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        req0_rvalid     = 1'b0;
        req1_rvalid     = 1'b0;
        clear_done      = 1'b0;
        mem_chip_select = 1'b0;
        mem_read_en     = 1'b0;
        mem_write_en    = 1'b0;
        mem_reset       = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                end else begin
                    req0_ready = sel0;
                    req1_ready = sel1;
                    if (sel0 || sel1)
                        state_nxt = sel_write ? WRITE : READ;
                end
            end
            WRITE: begin
                mem_chip_select = 1'b1;
                mem_write_en    = 1'b1;
                state_nxt       = IDLE;
            end
            READ: begin
                mem_chip_select = 1'b1;
                mem_read_en     = 1'b1;
                if (lat_cnt == 2'd0)
                    state_nxt = RESP;
            end
            RESP: begin
                req0_rvalid = !grant_q;
                req1_rvalid = grant_q;
                state_nxt   = IDLE;
            end
            CLEAR: begin
                mem_reset  = 1'b1;
                clear_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset silences every handshake and strobe and clears the memory with us.
        if (reset) begin
            req0_ready      = 1'b0;
            req1_ready      = 1'b0;
            req0_rvalid     = 1'b0;
            req1_rvalid     = 1'b0;
            clear_done      = 1'b0;
            mem_chip_select = 1'b0;
            mem_read_en     = 1'b0;
            mem_write_en    = 1'b0;
            mem_reset       = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            addr_q     <= 3'd0;
            wdata_q    <= 8'h00;
            lat_cnt    <= 2'd0;
            rdata      <= 8'h00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q     <= sel1 ? req1_address : req0_address;
                wdata_q    <= sel1 ? req1_wdata : req0_wdata;
                grant_q    <= sel1;
                last_grant <= sel1;
                lat_cnt    <= LAT_LOAD;
            end
            if (state == READ) begin
                if (lat_cnt == 2'd0)
                    rdata <= mem_data_out;
                else
                    lat_cnt <= lat_cnt - 2'd1;
            end
        end
    end

endmodule
